// File: rtl/bpsk_modulator.sv
// BPSK modulator: passes the carrier sample or its saturated negation for each
// data bit, and pops the next bit from a first-word-fall-through bit source
// at every bit boundary.
module bpsk_modulator #(
   parameter  int SAMPLE_W = 12,
   parameter  int SPB      = 16,
   localparam int CNT_W    = $clog2(SPB)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mod_en,
   input  logic [SAMPLE_W-1:0] sine_in,
   input  logic                sine_valid,
   input  logic                data_rdy,
   input  logic                data_bit,
   output logic                data_req,
   output logic [SAMPLE_W-1:0] mod_out,
   output logic                mod_valid,
   output logic                bit_active,
   output logic                underrun
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SPB - 1);
   localparam logic [SAMPLE_W-1:0] S_MIN    = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [SAMPLE_W-1:0] S_MAX    = {1'b0, {(SAMPLE_W-1){1'b1}}};

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                cur_bit_q;
   logic [SAMPLE_W-1:0] mod_out_q;
   logic                mod_valid_q;
   logic                underrun_q;

   logic [SAMPLE_W-1:0] neg_sine;
   logic [SAMPLE_W-1:0] mod_sample_d;
   logic                at_boundary;

   // Saturating negation: the most negative code has no positive twin, so it maps to full-scale positive
   always_comb begin
      neg_sine = S_MAX;
      if (sine_in != S_MIN) begin
         neg_sine = -sine_in;
      end
      mod_sample_d = cur_bit_q ? sine_in : neg_sine;
   end

   // Bit pop: start of a transmission from IDLE, or a continuous boundary while running; never in reset
   always_comb begin
      at_boundary = (state_q == RUN) && sine_valid && (cnt_q == CNT_LAST);
      data_req    = 1'b0;
      if (rst_n && mod_en && data_rdy) begin
         data_req = (state_q == IDLE) || at_boundary;
      end
   end

   // Single-process FSM holding the sample counter, current bit and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cur_bit_q   <= 1'b0;
         mod_out_q   <= '0;
         mod_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               mod_out_q   <= '0;
               mod_valid_q <= 1'b0;
               cnt_q       <= '0;
               if (mod_en && data_rdy) begin
                  cur_bit_q <= data_bit;
                  state_q   <= RUN;
               end
            end
            RUN: begin
               if (sine_valid) begin
                  mod_out_q   <= mod_sample_d;
                  mod_valid_q <= 1'b1;
                  if (cnt_q != CNT_LAST) begin
                     cnt_q <= cnt_q + 1'b1;
                  end else begin
                     // Boundary: the sample just taken still used the old bit
                     cnt_q <= '0;
                     if (mod_en && data_rdy) begin
                        cur_bit_q <= data_bit;
                     end else begin
                        state_q <= IDLE;
                        if (mod_en) begin
                           underrun_q <= 1'b1;
                        end
                     end
                  end
               end else begin
                  // Gap in carrier samples: freeze position in the bit, keep last sample
                  mod_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mod_out    = mod_out_q;
   assign mod_valid  = mod_valid_q;
   assign bit_active = (state_q == RUN);
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_bpsk_modulator.sv
// Directed bench for bpsk_modulator with SAMPLE_W=12, SPB=4.
module tb_bpsk_modulator;

   localparam int SAMPLE_W = 12;
   localparam int SPB      = 4;

   logic                clk;
   logic                rst_n;
   logic                mod_en;
   logic [SAMPLE_W-1:0] sine_in;
   logic                sine_valid;
   logic                data_rdy;
   logic                data_bit;
   logic                data_req;
   logic [SAMPLE_W-1:0] mod_out;
   logic                mod_valid;
   logic                bit_active;
   logic                underrun;

   int n_checks = 0;
   int n_errors = 0;

   bpsk_modulator #(
      .SAMPLE_W (SAMPLE_W),
      .SPB      (SPB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mod_en     (mod_en),
      .sine_in    (sine_in),
      .sine_valid (sine_valid),
      .data_rdy   (data_rdy),
      .data_bit   (data_bit),
      .data_req   (data_req),
      .mod_out    (mod_out),
      .mod_valid  (mod_valid),
      .bit_active (bit_active),
      .underrun   (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: apply inputs, check data_req before the edge, check registered outputs after it.
   task automatic cyc(input string tag, input logic rn, input logic en, input logic rdy,
                      input logic bt, input logic sv, input int sine,
                      input int req_e, input int val_e, input int out_e,
                      input int act_e, input int und_e);
      rst_n      = rn;
      mod_en     = en;
      data_rdy   = rdy;
      data_bit   = bt;
      sine_valid = sv;
      sine_in    = SAMPLE_W'(sine);
      #1;
      check({tag, ".data_req"}, int'(data_req), req_e);
      @(posedge clk);
      #1;
      check({tag, ".mod_valid"}, int'(mod_valid), val_e);
      check({tag, ".mod_out"}, int'($signed(mod_out)), out_e);
      check({tag, ".bit_active"}, int'(bit_active), act_e);
      check({tag, ".underrun"}, int'(underrun), und_e);
      $display("cycle %s: req=%0d valid=%0d out=%0d active=%0d underrun=%0d",
               tag, data_req, mod_valid, $signed(mod_out), bit_active, underrun);
   endtask

   initial begin
      rst_n = 1'b0; mod_en = 1'b1; data_rdy = 1'b1; data_bit = 1'b1;
      sine_valid = 1'b1; sine_in = '0;
      @(posedge clk);
      #1;

      // 1: reset with mod_en and data_rdy high
      //   tag       rn en rdy bt sv sine   req val out  act und
      cyc("rst0",    0, 1, 1, 1, 1, 100,    0, 0, 0,    0, 0);
      cyc("rst1",    0, 1, 1, 1, 1, 100,    0, 0, 0,    0, 0);

      // 2: bits 1 then 0, carrier 100..400, graceful stop at the end of bit 0
      cyc("t2s",     1, 1, 1, 1, 1, 100,    1, 0, 0,    1, 0);
      cyc("t2a",     1, 1, 1, 0, 1, 100,    0, 1, 100,  1, 0);
      cyc("t2b",     1, 1, 1, 0, 1, 200,    0, 1, 200,  1, 0);
      cyc("t2c",     1, 1, 1, 0, 1, 300,    0, 1, 300,  1, 0);
      cyc("t2d",     1, 1, 1, 0, 1, 400,    1, 1, 400,  1, 0);
      cyc("t2e",     1, 1, 0, 0, 1, 100,    0, 1, -100, 1, 0);
      cyc("t2f",     1, 1, 0, 0, 1, 200,    0, 1, -200, 1, 0);
      cyc("t2g",     1, 1, 0, 0, 1, 300,    0, 1, -300, 1, 0);
      cyc("t2h",     1, 0, 0, 0, 1, 400,    0, 1, -400, 0, 0);
      cyc("t2i",     1, 0, 0, 0, 1, 100,    0, 0, 0,    0, 0);

      // 3: bit 0 with full-scale inputs, saturation on the most negative code
      cyc("t3s",     1, 1, 1, 0, 1, 0,      1, 0, 0,    1, 0);
      cyc("t3a",     1, 1, 0, 0, 1, -2048,  0, 1, 2047, 1, 0);
      cyc("t3b",     1, 1, 0, 0, 1, 2047,   0, 1, -2047,1, 0);
      cyc("t3c",     1, 1, 0, 0, 1, -5,     0, 1, 5,    1, 0);
      cyc("t3d",     1, 0, 0, 0, 1, 5,      0, 1, -5,   0, 0);
      cyc("t3e",     1, 0, 0, 0, 1, 5,      0, 0, 0,    0, 0);

      // 4: single bit queued with mod_en held -> underrun, then restart keeps underrun set
      cyc("t4s",     1, 1, 1, 1, 1, 0,      1, 0, 0,    1, 0);
      cyc("t4a",     1, 1, 0, 0, 1, 10,     0, 1, 10,   1, 0);
      cyc("t4b",     1, 1, 0, 0, 1, 20,     0, 1, 20,   1, 0);
      cyc("t4c",     1, 1, 0, 0, 1, 30,     0, 1, 30,   1, 0);
      cyc("t4d",     1, 1, 0, 0, 1, 40,     0, 1, 40,   0, 1);
      cyc("t4e",     1, 1, 0, 0, 1, 50,     0, 0, 0,    0, 1);
      cyc("t4r",     1, 1, 1, 0, 1, 50,     1, 0, 0,    1, 1);
      cyc("t4f",     1, 1, 0, 0, 1, 50,     0, 1, -50,  1, 1);
      cyc("t4g",     1, 0, 0, 0, 1, 60,     0, 1, -60,  1, 1);
      cyc("t4h",     1, 0, 0, 0, 1, 70,     0, 1, -70,  1, 1);
      cyc("t4i",     1, 0, 0, 0, 1, 80,     0, 1, -80,  0, 1);

      // 5: mod_en dropped after the 2nd sample; bit completes with no pop even though data is ready
      cyc("t5s",     1, 1, 1, 1, 1, 0,      1, 0, 0,    1, 1);
      cyc("t5a",     1, 1, 1, 0, 1, 7,      0, 1, 7,    1, 1);
      cyc("t5b",     1, 1, 1, 0, 1, 8,      0, 1, 8,    1, 1);
      cyc("t5c",     1, 0, 1, 0, 1, 9,      0, 1, 9,    1, 1);
      cyc("t5d",     1, 0, 1, 0, 1, 10,     0, 1, 10,   0, 1);
      cyc("t5e",     1, 0, 1, 0, 1, 11,     0, 0, 0,    0, 1);

      // 6: sine_valid gap of 3 cycles mid-bit, then reset mid-bit
      cyc("t6s",     1, 1, 1, 1, 1, 0,      1, 0, 0,    1, 1);
      cyc("t6a",     1, 1, 1, 0, 1, 11,     0, 1, 11,   1, 1);
      cyc("t6g0",    1, 1, 1, 0, 0, 99,     0, 0, 11,   1, 1);
      cyc("t6g1",    1, 1, 1, 0, 0, 99,     0, 0, 11,   1, 1);
      cyc("t6g2",    1, 1, 1, 0, 0, 99,     0, 0, 11,   1, 1);
      cyc("t6b",     1, 1, 1, 0, 1, 12,     0, 1, 12,   1, 1);
      cyc("t6c",     1, 1, 1, 0, 1, 13,     0, 1, 13,   1, 1);
      cyc("t6d",     1, 1, 1, 0, 1, 14,     1, 1, 14,   1, 1);
      cyc("t6e",     1, 1, 1, 0, 1, 15,     0, 1, -15,  1, 1);
      cyc("t6r",     0, 1, 1, 0, 1, 16,     0, 0, 0,    0, 0);
      cyc("t6f",     1, 0, 0, 0, 1, 17,     0, 0, 0,    0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
